xor_stream_scrambler: RTL and testbench

- Streaming stage that feeds XOR-based checks: XORs each accepted data beat with an LFSR keystream and registers the result.
- Valid/ready on both sides; one output register; 1-cycle latency.
- Keystream restarts from SEED after a beat flagged last, so every packet scrambles identically.
- Descrambling is the same block with the same SEED.

---
 rtl/xor_stream_scrambler_pkg.sv | 26 ++
 rtl/xor_stream_scrambler_if.sv | 24 ++
 rtl/xor_stream_scrambler_lfsr.sv | 27 ++
 rtl/xor_stream_scrambler.sv | 79 +++++++
 tb/tb_xor_stream_scrambler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/xor_stream_scrambler_pkg.sv
// Shared types, defaults and LFSR helpers for the XOR stream scrambler.
// Optional parity output is enabled with the XSCR_PARITY_EN macro.
package xscr_pkg;

    localparam int unsigned XSCR_W    = 8;
    localparam logic [7:0]  XSCR_MASK = 8'hB8;
    localparam logic [7:0]  XSCR_SEED = 8'h01;

    typedef logic [XSCR_W-1:0] xscr_word_t;

    typedef struct packed {
        xscr_word_t data;
        logic       last;
    } xscr_beat_t;

    // Galois step: shift right, fold the mask in when a 1 falls out of bit 0.
    function automatic xscr_word_t lfsr_next(input xscr_word_t state, input xscr_word_t mask);
        return (state >> 1) ^ (state[0] ? mask : '0);
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    function automatic xscr_word_t legal_seed(input xscr_word_t seed);
        return (seed == '0) ? xscr_word_t'(1) : seed;
    endfunction

endpackage

// File: rtl/xor_stream_scrambler_if.sv
// Valid/ready beat stream carrying data and an end-of-packet flag.
// Used for both the upstream and downstream side of the scrambler.
interface xor_stream_scrambler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/xor_stream_scrambler_lfsr.sv
// Keystream register: Galois LFSR that steps per accepted beat and reloads
// the seed at packet boundaries.
module xscr_lfsr
    import xscr_pkg::*;
#(
    parameter int unsigned      WIDTH = XSCR_W,
    parameter logic [XSCR_W-1:0] SEED = XSCR_SEED,
    parameter logic [XSCR_W-1:0] MASK = XSCR_MASK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             reload,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= legal_seed(SEED);
        end else if (reload) begin
            state <= legal_seed(SEED);
        end else if (step) begin
            state <= lfsr_next(state, MASK);
        end
    end

endmodule

// File: rtl/xor_stream_scrambler.sv
// Single-register streaming stage that XORs each accepted beat with an LFSR
// keystream; XSCR_PARITY_EN adds a registered parity bit of the output beat.
module xor_stream_scrambler
    import xscr_pkg::*;
#(
    parameter int unsigned       WIDTH = XSCR_W,
    parameter logic [XSCR_W-1:0] SEED  = XSCR_SEED,
    parameter logic [XSCR_W-1:0] MASK  = XSCR_MASK
) (
    input  logic                    clk,
    input  logic                    reset,
    xor_stream_scrambler_if.slave   in_bus,
    xor_stream_scrambler_if.master  out_bus,
    output logic [15:0]             beat_count
`ifdef XSCR_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    logic             accept;
    logic             out_valid_q;
    xscr_beat_t       beat_q;
    logic [WIDTH-1:0] keystream;
    logic [WIDTH-1:0] scrambled;

    xscr_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .MASK  (MASK)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .step   (accept),
        .reload (accept && in_bus.last),
        .state  (keystream)
    );

    // Ready whenever the register is empty or being drained this cycle.
    assign in_bus.ready = !out_valid_q || out_bus.ready;
    assign accept       = in_bus.valid && in_bus.ready;
    assign scrambled    = in_bus.data ^ keystream;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            beat_q.data <= scrambled;
            beat_q.last <= in_bus.last;
        end else if (out_bus.ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (accept) begin
            beat_count <= beat_count + 16'd1;
        end
    end

`ifdef XSCR_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (accept) begin
            out_parity <= ^scrambled;
        end
    end
`endif

    assign out_bus.valid = out_valid_q;
    assign out_bus.data  = beat_q.data;
    assign out_bus.last  = beat_q.last;

endmodule

// File: tb/tb_xor_stream_scrambler.sv
// Self-checking bench for xor_stream_scrambler: vector table, backpressure,
// async reset and long-run period / counter-wrap sequences with a scoreboard.
module tb_xor_stream_scrambler;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] in_data;
        logic       in_last;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] beat_count;
`ifdef XSCR_PARITY_EN
    logic        out_parity;
`endif

    xor_stream_scrambler_if #(.WIDTH(8)) in_bus ();
    xor_stream_scrambler_if #(.WIDTH(8)) out_bus ();

    xor_stream_scrambler #(
        .WIDTH (8),
        .SEED  (8'h01),
        .MASK  (8'hB8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_bus     (in_bus),
        .out_bus    (out_bus),
        .beat_count (beat_count)
`ifdef XSCR_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ks_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Output monitor: every transferred beat must match the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_bus.valid === 1'b1 && out_bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: got unexpected beat %h expected none", out_bus.data);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", 32'(out_bus.data), 32'(mon_e.data));
                chk("sb_last", 32'(out_bus.last), 32'(mon_e.last));
`ifdef XSCR_PARITY_EN
                chk("sb_parity", 32'(out_parity), 32'(^mon_e.data));
`endif
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] e);
        bit done;
        done = 1'b0;
        in_bus.valid = 1'b1;
        in_bus.data  = d;
        in_bus.last  = l;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_bus.ready === 1'b1) begin
                sb.push_back(exp_t'{data: e, last: l});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_bus.valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic idle(input int unsigned n);
        in_bus.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ks;
        logic [7:0] e;

        vecs[0] = '{8'h00, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 8'hB8, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 8'h5C, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'h2E, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 8'hFE, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 8'hFE, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 8'h47, 1'b0};
        vecs[7] = '{8'h00, 1'b0, 8'h5C, 1'b0};
        vecs[8] = '{8'h00, 1'b1, 8'h2E, 1'b1};

        reset         = 1'b1;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        in_bus.last   = 1'b0;
        out_bus.ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_bus.valid), 32'd0);
        chk("rst_out_data",  32'(out_bus.data),  32'd0);
        chk("rst_out_last",  32'(out_bus.last),  32'd0);
        chk("rst_beat_count", 32'(beat_count),   32'd0);
        chk("rst_in_ready",  32'(in_bus.ready),  32'd1);
        #22;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: streaming, keystream values and reload after last.
        out_bus.ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].in_data, vecs[i].in_last, vecs[i].exp_data);
            chk("tbl_out_data", 32'(out_bus.data), 32'(vecs[i].exp_data));
            chk("tbl_out_last", 32'(out_bus.last), 32'(vecs[i].exp_last));
            if (i == 3) chk("count_after_4", 32'(beat_count), 32'd4);
        end
        idle(1);
        chk("drain_out_valid", 32'(out_bus.valid), 32'd0);
        chk("drain_hold_data", 32'(out_bus.data), 32'h2E);
        chk("count_after_tbl", 32'(beat_count), 32'd9);

        // Backpressure: one beat held, next beat stalled for 3 cycles.
        out_bus.ready = 1'b0;
        send(8'h00, 1'b0, 8'h01);
        in_bus.valid = 1'b1;
        in_bus.data  = 8'h00;
        in_bus.last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_bus.ready),  32'd0);
            chk("bp_out_valid", 32'(out_bus.valid), 32'd1);
            chk("bp_out_data",  32'(out_bus.data),  32'h01);
            @(posedge clk);
            #1;
        end
        chk("bp_count", 32'(beat_count), 32'd10);
        out_bus.ready = 1'b1;
        send(8'h00, 1'b0, 8'hB8);
        chk("bp_release_data", 32'(out_bus.data), 32'hB8);
        idle(2);

        // Asynchronous reset while a beat is held mid-packet.
        send(8'h00, 1'b0, 8'h5C);
        send(8'h00, 1'b0, 8'h2E);
        out_bus.ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_bus.valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_bus.data),  32'd0);
        chk("mid_rst_count",     32'(beat_count),    32'd0);
        chk("mid_rst_in_ready",  32'(in_bus.ready),  32'd1);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_bus.ready = 1'b1;
        send(8'h00, 1'b0, 8'h01);
        chk("post_rst_data", 32'(out_bus.data), 32'h01);
        idle(2);

        // Period 255 and 16-bit counter wrap over 65536 full-rate beats.
        #3;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ks = 8'h01;
        for (int i = 0; i < 65536; i++) begin
            e = (i == 0 || i == 255) ? 8'h01 : ks;
            send(8'h00, 1'b0, e);
            ks = ks_step(ks);
        end
        chk("wrap_count", 32'(beat_count), 32'd0);
        idle(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
